// File: rtl/irq_sched.sv
// irq_sched: synchronizes raw interrupt lines, maintains MIP and issues one
// prioritized trap request at a time with a post-ack hold-off.
module irq_sched #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_msip,
    input  logic        irq_mtip,
    input  logic        irq_meip,
    input  logic        irq_seip,
    input  logic [63:0] mie,
    input  logic [63:0] mideleg,
    input  logic        mstatus_mie,
    input  logic        mstatus_sie,
    input  logic [1:0]  priv,
    input  logic        mip_we,
    input  logic [63:0] mip_wdata,
    output logic [63:0] mip,
    output logic        irq_req,
    output logic [3:0]  irq_cause,
    output logic        irq_deleg,
    input  logic        irq_ack
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]  lines;
    logic        ssip, stip, seip_sw;
    logic [2:0]  hold_cnt;
    logic [63:0] en;
    logic [15:0] en16;
    logic        m_ok, s_ok, any_en, withdraw;
    logic [3:0]  win;
    logic        unused_ok;

    // line order within each stage: {seip, meip, mtip, msip}
    always_ff @(posedge clk or posedge rst)
        if (rst)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], {irq_seip, irq_meip, irq_mtip, irq_msip}};

    always_ff @(posedge clk or posedge rst)
        if (rst)
            {seip_sw, stip, ssip} <= '0;
        else if (mip_we)
            {seip_sw, stip, ssip} <= {mip_wdata[9], mip_wdata[5], mip_wdata[1]};

    assign unused_ok = ^{mip_wdata[63:10], mip_wdata[8:6], mip_wdata[4:2], mip_wdata[0]};
    assign lines = sync_q[SYNC_STAGES-1];
    assign mip = {52'd0, lines[2], 1'b0, seip_sw | lines[3], 1'b0, lines[1], 1'b0,
                  stip, 1'b0, lines[0], 1'b0, ssip, 1'b0};

    assign m_ok = priv != 2'd3 || mstatus_mie;
    assign s_ok = priv == 2'd0 || (priv == 2'd1 && mstatus_sie);
    assign en = mip & mie & ((mideleg & {64{s_ok}}) | (~mideleg & {64{m_ok}}));
    assign en16 = en[15:0];
    assign any_en = |en;
    assign win = en[11] ? 4'd11 : en[3] ? 4'd3 : en[7] ? 4'd7 :
                 en[9] ? 4'd9 : en[1] ? 4'd1 : 4'd5;
    assign withdraw = !en16[irq_cause];

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;

    // ack takes precedence over withdraw while requesting
    always_comb
        state_nx = state == IDLE ? (any_en ? REQ : IDLE) :
                   state == REQ  ? (irq_ack ? HOLD : withdraw ? IDLE : REQ) :
                   (hold_cnt <= 3'd1 ? IDLE : HOLD);

    always_comb
        irq_req = state == REQ;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hold_cnt  <= '0;
            irq_cause <= '0;
            irq_deleg <= 1'b0;
        end else begin
            if (state == IDLE && any_en) begin
                irq_cause <= win;
                irq_deleg <= mideleg[{2'b00, win}];
            end
            hold_cnt <= state == REQ && irq_ack ? 3'(HOLD_CYCLES) :
                        state == HOLD && hold_cnt != 3'd0 ? hold_cnt - 3'd1 : hold_cnt;
        end
endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched: directed scenarios plus randomized traffic against a
// cycle-level reference model of the interrupt scheduler.
module tb_irq_sched;
    localparam int SS = 2;
    localparam int HC = 2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        irq_msip, irq_mtip, irq_meip, irq_seip;
    logic [63:0] mie, mideleg, mip_wdata, mip;
    logic        mstatus_mie, mstatus_sie, mip_we, irq_req, irq_deleg, irq_ack;
    logic [1:0]  priv;
    logic [3:0]  irq_cause;
    int checks = 0;
    int failures = 0;
    logic [3:0] sq[$];
    logic s_ss, s_st, s_se;
    int m_mode, m_left, m_cause;
    logic m_deleg;
    int pri [6] = '{11, 3, 7, 9, 1, 5};

    always #5 clk = ~clk;

    irq_sched #(.SYNC_STAGES(SS), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .rst(rst), .irq_msip(irq_msip), .irq_mtip(irq_mtip),
        .irq_meip(irq_meip), .irq_seip(irq_seip), .mie(mie), .mideleg(mideleg),
        .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie), .priv(priv),
        .mip_we(mip_we), .mip_wdata(mip_wdata), .mip(mip), .irq_req(irq_req),
        .irq_cause(irq_cause), .irq_deleg(irq_deleg), .irq_ack(irq_ack)
    );

    // front of sq is the synchronized view {seip, meip, mtip, msip}
    function automatic logic [63:0] model_mip();
        logic [63:0] v = '0;
        logic [3:0] l = sq[0];
        v[1] = s_ss;
        v[5] = s_st;
        v[3] = l[0];
        v[7] = l[1];
        v[11] = l[2];
        v[9] = s_se | l[3];
        return v;
    endfunction

    function automatic bit model_en(int i);
        logic [63:0] m = model_mip();
        if (!(m[i] && mie[i])) return 1'b0;
        if (mideleg[i]) return priv == 2'd0 || (priv == 2'd1 && mstatus_sie);
        return priv != 2'd3 || mstatus_mie;
    endfunction

    function automatic int model_win();
        foreach (pri[k]) if (model_en(pri[k])) return pri[k];
        return -1;
    endfunction

    task automatic model_reset();
        sq.delete();
        repeat (SS) sq.push_back(4'd0);
        {s_ss, s_st, s_se} = 3'b000;
        m_mode = 0;
        m_left = 0;
        m_cause = 0;
        m_deleg = 1'b0;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        chk("mip", mip, model_mip());
        chk("irq_req", {63'd0, irq_req}, {63'd0, m_mode == 1});
        chk("irq_cause", {60'd0, irq_cause}, 64'(m_cause));
        chk("irq_deleg", {63'd0, irq_deleg}, {63'd0, m_deleg});
    endtask

    task automatic step();
        int w;
        bit still;
        w = model_win();
        still = model_en(m_cause);
        if (rst) model_reset();
        else begin
            if (m_mode == 0) begin
                if (w >= 0) begin
                    m_mode = 1;
                    m_cause = w;
                    m_deleg = mideleg[w];
                end
            end else if (m_mode == 1) begin
                if (irq_ack) begin
                    m_mode = 2;
                    m_left = HC;
                end else if (!still) m_mode = 0;
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
            if (mip_we) {s_se, s_st, s_ss} = {mip_wdata[9], mip_wdata[5], mip_wdata[1]};
            sq.push_back({irq_seip, irq_meip, irq_mtip, irq_msip});
            void'(sq.pop_front());
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        {irq_msip, irq_mtip, irq_meip, irq_seip} = 4'b0000;
        mie = '0;
        mideleg = '0;
        mip_wdata = '0;
        {mstatus_mie, mstatus_sie, mip_we, irq_ack} = 4'b0000;
        priv = 2'd0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        {irq_msip, irq_mtip, irq_meip, irq_seip} = 4'b0000;
        mie = '0;
        mideleg = '0;
        mip_wdata = '0;
        {mstatus_mie, mstatus_sie, mip_we, irq_ack} = 4'b0000;
        priv = 2'd0;
        #1 compare();
        run(2);
        rst = 1'b0;
        // timer interrupt in U-mode, ack and hold-off
        mie = 64'h80;
        irq_mtip = 1'b1;
        run(2);
        chk("d1_early", irq_req, 0);
        step();
        chk("d1_req", irq_req, 1);
        chk("d1_cause", irq_cause, 7);
        chk("d1_deleg", irq_deleg, 0);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("d1_acked", irq_req, 0);
        run(2);
        chk("d1_hold", irq_req, 0);
        step();
        chk("d1_rearb", irq_req, 1);
        // M-mode global enable gating
        reset_dut();
        priv = 2'd3;
        {irq_msip, irq_mtip, irq_meip, irq_seip} = 4'b1111;
        mie = '1;
        run(4);
        chk("d2_masked", irq_req, 0);
        mstatus_mie = 1'b1;
        step();
        chk("d2_req", irq_req, 1);
        chk("d2_cause", irq_cause, 11);
        // soft SEIP delegated to S-mode
        reset_dut();
        priv = 2'd1;
        mstatus_sie = 1'b1;
        mideleg = 64'h200;
        mie = 64'h200;
        mip_we = 1'b1;
        mip_wdata = 64'h200;
        step();
        mip_we = 1'b0;
        chk("d3_mip9", mip[9], 1);
        step();
        chk("d3_req", irq_req, 1);
        chk("d3_cause", irq_cause, 9);
        chk("d3_deleg", irq_deleg, 1);
        reset_dut();
        priv = 2'd3;
        mstatus_sie = 1'b1;
        mideleg = 64'h200;
        mie = 64'h200;
        mip_we = 1'b1;
        mip_wdata = 64'h200;
        step();
        mip_we = 1'b0;
        run(2);
        chk("d3_mmode", irq_req, 0);
        // cause frozen while a higher-priority line arrives
        reset_dut();
        mie = 64'h880;
        irq_mtip = 1'b1;
        run(3);
        chk("d4_cause7", irq_cause, 7);
        irq_meip = 1'b1;
        run(4);
        chk("d4_frozen", irq_cause, 7);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        run(2);
        chk("d4_hold", irq_req, 0);
        step();
        chk("d4_req", irq_req, 1);
        chk("d4_cause11", irq_cause, 11);
        // withdraw, then ack coinciding with withdraw
        reset_dut();
        mie = 64'h88;
        irq_msip = 1'b1;
        run(3);
        chk("d5_cause3", irq_cause, 3);
        irq_msip = 1'b0;
        run(2);
        chk("d5_still", irq_req, 1);
        step();
        chk("d5_withdrawn", irq_req, 0);
        irq_msip = 1'b1;
        run(3);
        chk("d5_req2", irq_req, 1);
        irq_msip = 1'b0;
        irq_mtip = 1'b1;
        run(2);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("d5_ackwin", irq_req, 0);
        step();
        chk("d5_in_hold", irq_req, 0);
        run(2);
        chk("d5_cause7", irq_cause, 7);
        // asynchronous reset during a request
        reset_dut();
        mie = 64'h8;
        irq_msip = 1'b1;
        run(3);
        chk("d6_req", irq_req, 1);
        rst = 1'b1;
        irq_msip = 1'b0;
        model_reset();
        #1;
        chk("d6_async_req", irq_req, 0);
        chk("d6_async_mip", mip, 0);
        step();
        rst = 1'b0;
        run(4);
        chk("d6_quiet", irq_req, 0);
        // randomized traffic
        reset_dut();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) irq_msip = ~irq_msip;
            if ($urandom_range(0, 7) == 0) irq_mtip = ~irq_mtip;
            if ($urandom_range(0, 7) == 0) irq_meip = ~irq_meip;
            if ($urandom_range(0, 7) == 0) irq_seip = ~irq_seip;
            if ($urandom_range(0, 19) == 0) mie = {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) mideleg = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) priv = $urandom_range(0, 2) == 2 ? 2'd3 : 2'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) {mstatus_mie, mstatus_sie} = 2'($urandom_range(0, 3));
            mip_we = $urandom_range(0, 9) == 0;
            mip_wdata = {$urandom, $urandom};
            irq_ack = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                model_reset();
                #1 compare();
                step();
                rst = 1'b0;
            end else step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
